// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin 2:1 mux arbiter.
package mux_pkg;

  // Arbiter FSM encodings; code 2'd3 is unused and recovers to idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  // Default cap on consecutive grant cycles while the other source waits.
  localparam int MAX_BURST_DEF = 4;

  // Burst counter width; never narrower than one bit.
  function automatic int cnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/mux_comportamental.sv
// Behavioural 1-bit 2:1 mux; sel = 1 picks D[1].
module mux_comportamental (
  input  logic [1:0] D,
  input  logic       sel,
  output logic       y
);

  // Pure select, no state.
  always_comb y = D[sel];

endmodule

// File: rtl/mux_arbiter.sv
// Two-source round-robin arbiter that owns the 2:1 mux select and
// registers the selected bit with a valid flag. Grants are bounded to
// MAX_BURST cycles while the other source is waiting.
module mux_arbiter
  import mux_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] D,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       y,
  output logic       y_valid
);

  localparam int             CW      = cnt_width(MAX_BURST);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST - 1);

  state_t          state, state_nx;
  logic            last;      // most recently granted source
  logic [CW-1:0]   cnt;       // cycles the current grant has been held
  logic            burst_end; // current owner has used its full burst
  logic            enter;     // moving into a grant state this edge
  logic            mux_y;

  assign burst_end = (cnt == CNT_MAX);
  assign enter     = (state_nx != state) && (state_nx != ST_IDLE);

  // Next-state: round-robin on ties, release on drop, forced handover on burst end.
  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE: begin
        case (req)
          2'b01:   state_nx = ST_G0;
          2'b10:   state_nx = ST_G1;
          2'b11:   state_nx = last ? ST_G0 : ST_G1;
          default: state_nx = ST_IDLE;
        endcase
      end
      ST_G0: begin
        if (!req[0])                 state_nx = req[1] ? ST_G1 : ST_IDLE;
        else if (req[1] && burst_end) state_nx = ST_G1;
        else                         state_nx = ST_G0;
      end
      ST_G1: begin
        if (!req[1])                 state_nx = req[0] ? ST_G0 : ST_IDLE;
        else if (req[0] && burst_end) state_nx = ST_G0;
        else                         state_nx = ST_G1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register plus grant/select/pointer/counter bookkeeping.
  // gnt and sel are loaded from the next state so they always match the
  // registered state; sel is left alone in idle so the mux keeps its path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt   <= 2'b00;
      sel   <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state_nx)
        ST_G0: begin
          gnt <= 2'b01;
          sel <= 1'b0;
        end
        ST_G1: begin
          gnt <= 2'b10;
          sel <= 1'b1;
        end
        default: gnt <= 2'b00;
      endcase
      if (enter) begin
        last <= (state_nx == ST_G1);
        cnt  <= '0;
      end else if (state_nx != ST_IDLE && !burst_end) begin
        // Saturate so a late request from the other side switches at once.
        cnt <= cnt + 1'b1;
      end
    end
  end

  mux_comportamental u_mux (
    .D   (D),
    .sel (sel),
    .y   (mux_y)
  );

  // Output stage: y tracks the mux unconditionally; y_valid marks granted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      y       <= mux_y;
      y_valid <= |gnt;
    end
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter that owns the select line of a 1-bit 2:1 mux and shares its output between two sources. Each source raises a request. The arbiter grants one source at a time, holds the grant for a bounded burst, and steers the mux. It registers the selected data bit with a valid flag. It sits directly in front of the 2:1 mux datapath and replaces the free-running select toggle used in bench-level experiments.

## Interface
- MAX_BURST, 4, maximum consecutive grant cycles for one source while the other is requesting; legal range ≥1
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- req  input  2  request per source; bit i = source i
- D  input  2  data per source; D[i] belongs to source i
- gnt  output  2  registered one-hot grant; 2'b00 when idle
- sel  output  1  registered mux select; 1 = source 1
- y  output  1  registered mux output
- y_valid  output  1  high when y carries data from a granted cycle

## Operation
- FSM states: IDLE, G0, G1. The outputs are decoded from registered state: gnt = 2'b01 in G0, 2'b10 in G1, 2'b00 in IDLE.
- sel = 0 in G0 and 1 in G1. In IDLE, sel holds its last value.
- last: a 1-bit pointer to the most recently granted source. It updates on entry to G0 or G1.
- cnt: a burst counter of width max(1,$clog2(MAX_BURST)). It is cleared on every entry to G0 or G1 and increments each cycle the state is held.

Transitions from IDLE:
- req = 01 goes to G0.
- req = 10 goes to G1.
- req = 11 goes to the source ≠ last.
- req = 00 stays in IDLE.

Transitions from Gi (j = other source):
- req[i] = 0 and req[j] = 1: go to Gj.
- req[i] = 0 and req[j] = 0: go to IDLE.
- req[i] = 1, req[j] = 1, and cnt == MAX_BURST−1: forced switch to Gj.
- req[i] = 1 otherwise: stay in Gi. cnt saturates at MAX_BURST−1 while req[j] = 0. A later req[j] therefore forces a switch at the next edge.

MAX_BURST = 1: with both sources requesting, the grant alternates every cycle.

Datapath:
- Every edge: y ← D[sel_current] and y_valid ← |gnt_current, where *_current means the registered values before the edge.
- y follows the mux even when y_valid = 0. Consumers must gate on y_valid.

Reset:
- Values after a reset edge: state = IDLE, gnt = 00, sel = 0, last = 1 (so source 0 wins the first tie), cnt = 0, y = 0, y_valid = 0.
- rst asserted mid-burst aborts the grant at that edge. No partial state survives.
- rst has priority over all transitions.

## Timing
- Request to grant: req sampled at edge k gives gnt valid after edge k. Minimum latency is 1 cycle.
- Grant to data: D of the granted source sampled at edge k+1 gives y/y_valid after edge k+1.
- Release: deasserting req[i] before edge m gives gnt[i] low after edge m, and y_valid low after edge m+1. Exactly one more valid beat follows the last grant cycle.
- Handover with both requesting: back-to-back. There is no idle cycle between Gi and Gj, and y_valid stays high continuously.
- Maximum wait for a requester: MAX_BURST cycles after the other source's grant begins.

## Structure
Shared package mux_pkg holds:
- state encodings ST_IDLE = 2'd0, ST_G0 = 2'd1, ST_G1 = 2'd2
- default MAX_BURST

One sub-module is natural: the existing 2:1 mux, mux_comportamental. It is instantiated for the D/sel datapath, with its output registered into y here. The FSM, counter and last pointer live in mux_arbiter.

## Test plan
- Reset: hold rst for 2 cycles with req = 11, D = 11. Then gnt = 00, sel = 0, y = 0, y_valid = 0. On release, G0 is granted first.
- Single requester: req = 01 for 10 cycles while D[0] toggles every cycle. gnt stays 01 throughout (no forced switch). y equals D[0] delayed one cycle, and y_valid stays high for 10 cycles.
- Contention, MAX_BURST = 4, req = 11 held: gnt pattern is 01×4, 10×4, 01×4. sel follows, and y_valid never drops.
- Early release: in G0 at cnt = 1, drop req[0] with req[1] = 1. gnt goes to 10 at the next edge, and cnt restarts at 0.
- Late arrival after saturation: req = 01 for 8 cycles, then req = 11. gnt becomes 10 after the next edge.
- Reset mid-burst: assert rst during G1 with cnt = 2. After that edge, gnt = 00 and y_valid = 0. After release with req = 11, the grant goes to G0.
